// File: rtl/btn_debounce_pkg.sv
// ---------------------------------------------------------------------------
// btn_debounce_pkg
//
// Purpose:
//   Shared constants and types for the push-button conditioning front end.
//   Holds the debounce FSM state encodings, the default debounce settings
//   and the per-cycle event bundle produced by the FSM next-state logic.
//   Later input stages that reuse the same debounce scheme import this
//   package so that state encodings stay identical across the codebase.
//
// Contents:
//   state_t                  2-bit FSM state type
//   ST_IDLE .. ST_DISARMING  state encodings (legacy-compatible constants)
//   DEFAULT_DEBOUNCE_CYCLES  default stable-sample requirement
//   DEFAULT_CNT_W            default stability counter width
//   DEFAULT_GLITCH_W         default rejected-glitch counter width
//   fsm_evt_t                one-cycle events decided by the FSM
// ---------------------------------------------------------------------------
package btn_debounce_pkg;

  typedef logic [1:0] state_t;

  // State encodings. Bit 1 is the accepted level the state belongs to and
  // bit 0 marks a candidate (still-counting) state.
  localparam logic [1:0] ST_IDLE      = 2'd0;  // accepted level 0
  localparam logic [1:0] ST_ARMING    = 2'd1;  // candidate level 1
  localparam logic [1:0] ST_HELD      = 2'd2;  // accepted level 1
  localparam logic [1:0] ST_DISARMING = 2'd3;  // candidate level 0

  // Defaults sized for simulation; CNT_W bounds the largest usable setting.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_W           = 16;
  localparam int DEFAULT_GLITCH_W        = 8;

  // Events decided combinationally in a cycle and registered by the top.
  // 'rise' / 'fall' are accepted level changes, 'reject' is an aborted
  // candidate (a glitch).
  typedef struct packed {
    logic rise;
    logic fall;
    logic reject;
  } fsm_evt_t;

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   Two-flop synchroniser for asynchronous inputs entering the clk domain.
//   The first stage may go metastable; only the second stage is used by
//   downstream logic. Both stages clear to 0 on synchronous reset so that a
//   level held high through reset is seen as a fresh 0->1 edge afterwards.
//
// Parameters:
//   WIDTH  number of independent single-bit lines synchronised in parallel
//
// Ports:
//   clk    input   1      system clock
//   reset  input   1      synchronous, active-high reset
//   d      input   WIDTH  asynchronous input lines
//   q      output  WIDTH  synchronised lines, two clk cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // sync1 / sync2 stages of the chain.
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= d;
      sync2_reg <= sync1_reg;
    end
  end

  assign q = sync2_reg;

endmodule : sync_2ff

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Purpose:
//   Conditions a raw, bouncy push-button into a clean registered level plus
//   single-cycle press / release pulses. press_pulse is meant to drive a
//   downstream counter's count enable so each physical press advances it
//   exactly once. Candidate level changes that are not stable for
//   DEBOUNCE_CYCLES consecutive synchronised samples are rejected and
//   counted in a saturating glitch counter.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive identical samples needed to accept a change
//                    (1..65535, must be < 2**CNT_W)
//   CNT_W            stability counter width
//   GLITCH_W         rejected-glitch counter width
//
// Ports:
//   clk            input   1         system clock, all logic on posedge
//   reset          input   1         synchronous, active-high reset
//   btn_in         input   1         raw asynchronous button input
//   btn_level      output  1         debounced level, registered
//   press_pulse    output  1         one-cycle pulse on accepted 0->1
//   release_pulse  output  1         one-cycle pulse on accepted 1->0
//   glitch_cnt     output  GLITCH_W  rejected transitions, saturating
//
// Timing:
//   btn_in first sampled high at posedge N (and held) gives btn_level=1 and
//   press_pulse=1 after posedge N+1+DEBOUNCE_CYCLES: two synchroniser
//   stages, then DEBOUNCE_CYCLES FSM samples, with the pulse and level
//   registered on the edge that takes the last sample. Release mirrors it.
// ---------------------------------------------------------------------------
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int GLITCH_W        = DEFAULT_GLITCH_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_in,
  output logic                btn_level,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  // The sample that completes a candidate is the one where cnt+1 reaches
  // this value; the entry sample from IDLE/HELD already counts as one.
  localparam logic [CNT_W-1:0]    CNT_TARGET    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE       = CNT_W'(1);
  localparam bit                  SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX    = '1;
  localparam logic [GLITCH_W-1:0] GLITCH_ONE    = GLITCH_W'(1);

  // -------------------------------------------------------------------------
  // Synchroniser: the FSM only ever looks at the second flop.
  // -------------------------------------------------------------------------
  logic sync_btn;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync_btn)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_next;
  logic [CNT_W-1:0]    cnt_inc;
  fsm_evt_t            evt_next;

  logic                level_reg;
  logic                level_next;
  logic                press_reg;
  logic                release_reg;
  logic [GLITCH_W-1:0] glitch_reg;
  logic [GLITCH_W-1:0] glitch_next;

  assign cnt_inc = cnt_reg + CNT_ONE;

  // -------------------------------------------------------------------------
  // FSM next-state logic
  //
  // Candidate states count samples that agree with the candidate level. Any
  // disagreeing sample aborts back to the accepted state and flags a reject.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    evt_next   = '0;

    case (state_reg)
      ST_IDLE: begin
        if (sync_btn) begin
          if (SINGLE_SAMPLE) begin
            // One sample is enough: accept immediately.
            state_next    = ST_HELD;
            cnt_next      = '0;
            evt_next.rise = 1'b1;
          end else begin
            state_next = ST_ARMING;
            cnt_next   = CNT_ONE;
          end
        end
      end

      ST_ARMING: begin
        if (sync_btn) begin
          if (cnt_inc == CNT_TARGET) begin
            state_next    = ST_HELD;
            cnt_next      = '0;
            evt_next.rise = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          state_next      = ST_IDLE;
          cnt_next        = '0;
          evt_next.reject = 1'b1;
        end
      end

      ST_HELD: begin
        if (!sync_btn) begin
          if (SINGLE_SAMPLE) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            evt_next.fall = 1'b1;
          end else begin
            state_next = ST_DISARMING;
            cnt_next   = CNT_ONE;
          end
        end
      end

      ST_DISARMING: begin
        if (!sync_btn) begin
          if (cnt_inc == CNT_TARGET) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            evt_next.fall = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          // Bounce back to 1 before the release was confirmed.
          state_next      = ST_HELD;
          cnt_next        = '0;
          evt_next.reject = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output next values
  // -------------------------------------------------------------------------
  always_comb begin
    level_next = level_reg;
    if (evt_next.rise) begin
      level_next = 1'b1;
    end else if (evt_next.fall) begin
      level_next = 1'b0;
    end
  end

  // Saturate rather than wrap so a noisy input cannot fake a low count.
  always_comb begin
    glitch_next = glitch_reg;
    if (evt_next.reject && (glitch_reg != GLITCH_MAX)) begin
      glitch_next = glitch_reg + GLITCH_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Registers. Reset overrides every transition decided in the same cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      glitch_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      // Pulses are registered on the same edge the level changes, so they
      // coincide with the first cycle of the new level and last one cycle.
      press_reg   <= evt_next.rise;
      release_reg <= evt_next.fall;
      glitch_reg  <= glitch_next;
    end
  end

  assign btn_level     = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign glitch_cnt    = glitch_reg;

endmodule : btn_debounce
